// File: rtl/cr_osf_tlv_tx_if.sv
// Request handshake, outbound 64-bit TLV stream and statistic strobes of cr_osf_tlv_tx.
// master = the transmitter, slave = the environment driving requests and sinking the stream.
interface cr_osf_tlv_tx_if #(
  parameter int MAX_WORDS = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic [7:0]              req_type;
  logic [2:0]              req_words;
  logic [3:0]              req_last_bytes;
  logic [64*MAX_WORDS-1:0] req_payload;

  logic                    ob_tvalid;
  logic                    ob_tready;
  logic [63:0]             ob_tdata;
  logic [7:0]              ob_tstrb;
  logic [1:0]              ob_tuser;
  logic                    ob_tlast;

  logic                    tx_frame_stb;
  logic                    tx_bytes_stb;
  logic [3:0]              tx_bytes_amt;
  logic                    tx_stall;

  modport master (
    input  req_valid, req_type, req_words, req_last_bytes, req_payload, ob_tready,
    output req_ready, ob_tvalid, ob_tdata, ob_tstrb, ob_tuser, ob_tlast,
    output tx_frame_stb, tx_bytes_stb, tx_bytes_amt, tx_stall
  );

  modport slave (
    output req_valid, req_type, req_words, req_last_bytes, req_payload, ob_tready,
    input  req_ready, ob_tvalid, ob_tdata, ob_tstrb, ob_tuser, ob_tlast,
    input  tx_frame_stb, tx_bytes_stb, tx_bytes_amt, tx_stall
  );
endinterface

// File: rtl/cr_osf_tlv_tx.sv
// TLV frame transmitter: one header beat plus 0..MAX_WORDS payload beats per request,
// with per-frame / per-beat statistic strobes. All outputs come straight from flops.
module cr_osf_tlv_tx #(
  parameter int MAX_WORDS = 4
) (
  input logic             clk,
  input logic             rst,
  cr_osf_tlv_tx_if.master tx
);
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  localparam logic [2:0] MAX_W = 3'(MAX_WORDS);
  localparam int         PW    = 64 * MAX_WORDS;

  state_t          state_q, state_d;
  logic [7:0]      type_q, type_d;
  logic [2:0]      words_q, words_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      lb_q, lb_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic [15:0]     seq_q, seq_d;

  logic            req_ready_q, req_ready_d;
  logic            tvalid_q, tvalid_d;
  logic [63:0]     tdata_q, tdata_d;
  logic [7:0]      tstrb_q, tstrb_d;
  logic [1:0]      tuser_q, tuser_d;
  logic            frame_stb_q, bytes_stb_q, stall_q;
  logic [3:0]      bytes_amt_q, amt_d;

  logic            hs, beat, last_d;
  logic [7:0]      len_d, mask_d;

  assign hs   = tx.req_valid && req_ready_q;
  assign beat = tvalid_q && tx.ob_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      type_q      <= '0;
      words_q     <= '0;
      idx_q       <= '0;
      lb_q        <= 4'd8;
      payload_q   <= '0;
      seq_q       <= '0;
      req_ready_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tuser_q     <= '0;
      frame_stb_q <= 1'b0;
      bytes_stb_q <= 1'b0;
      bytes_amt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      words_q     <= words_d;
      idx_q       <= idx_d;
      lb_q        <= lb_d;
      payload_q   <= payload_d;
      seq_q       <= seq_d;
      req_ready_q <= req_ready_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tstrb_q     <= tstrb_d;
      tuser_q     <= tuser_d;
      // Output flops mirror state_q, so the strobe source can be read from state_q.
      frame_stb_q <= beat && (state_q == HDR);
      bytes_stb_q <= beat && (state_q == PAY);
      bytes_amt_q <= (beat && (state_q == PAY)) ? amt_d : 4'd0;
      stall_q     <= tvalid_q && !tx.ob_tready;
    end
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    words_d   = words_q;
    idx_d     = idx_q;
    lb_d      = lb_q;
    payload_d = payload_q;
    seq_d     = seq_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d   = HDR;
        type_d    = tx.req_type;
        words_d   = (tx.req_words > MAX_W) ? MAX_W : tx.req_words;
        lb_d      = (tx.req_last_bytes == 4'd0 || tx.req_last_bytes > 4'd8) ? 4'd8
                                                                            : tx.req_last_bytes;
        payload_d = tx.req_payload;
      end
      HDR: if (beat) begin
        seq_d   = seq_q + 16'd1;
        idx_d   = 3'd0;
        state_d = (words_q == 3'd0) ? IDLE : PAY;
      end
      PAY: if (beat) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == words_q - 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values and registered, keeping them glitch-free
  // and free of any combinational path from ob_tready.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    tvalid_d    = 1'b0;
    tdata_d     = '0;
    tstrb_d     = '0;
    tuser_d     = '0;
    len_d       = {5'd0, words_d} + 8'd1;
    last_d      = (idx_d == words_d - 3'd1);
    mask_d      = 8'hFF >> (4'd8 - lb_d);
    case (state_d)
      HDR: begin
        tvalid_d = 1'b1;
        tdata_d  = {32'h0, seq_d, len_d, type_d};
        tstrb_d  = 8'hFF;
        tuser_d  = {words_d == 3'd0, 1'b1};
      end
      PAY: begin
        tvalid_d = 1'b1;
        tdata_d  = payload_d[64*int'(idx_d) +: 64];
        tstrb_d  = last_d ? mask_d : 8'hFF;
        tuser_d  = {last_d, 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    amt_d = '0;
    for (int k = 0; k < 8; k++) amt_d = amt_d + {3'b000, tstrb_q[k]};
  end

  assign tx.req_ready    = req_ready_q;
  assign tx.ob_tvalid    = tvalid_q;
  assign tx.ob_tdata     = tdata_q;
  assign tx.ob_tstrb     = tstrb_q;
  assign tx.ob_tuser     = tuser_q;
  assign tx.ob_tlast     = tuser_q[1];
  assign tx.tx_frame_stb = frame_stb_q;
  assign tx.tx_bytes_stb = bytes_stb_q;
  assign tx.tx_bytes_amt = bytes_amt_q;
  assign tx.tx_stall     = stall_q;
endmodule

// File: tb/tb_cr_osf_tlv_tx.sv
// Directed bench for cr_osf_tlv_tx: every observation packs beat and stat outputs into one
// vector and compares it with a hand-computed expectation, sampled on the falling edge.
module tb_cr_osf_tlv_tx;
  localparam int MW = 4;
  localparam logic [7:0] CQE = 8'hC1, RQE = 8'hA2, DATA = 8'hD3;
  localparam logic [63:0] P0 = 64'h0011_2233_4455_6677, P1 = 64'h8899_AABB_CCDD_EEFF,
                          P2 = 64'hDEAD_BEEF_0BAD_F00D, P3 = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cr_osf_tlv_tx_if #(.MAX_WORDS(MW)) bus ();
  cr_osf_tlv_tx #(.MAX_WORDS(MW)) dut (.clk(clk), .rst(rst), .tx(bus));

  int n_pass  = 0;
  int n_total = 0;

  // {tvalid, tlast, tuser, tstrb, tdata, req_ready, frame_stb, bytes_stb, bytes_amt, stall}
  logic [83:0] obs;
  assign obs = {bus.ob_tvalid, bus.ob_tlast, bus.ob_tuser, bus.ob_tstrb, bus.ob_tdata,
                bus.req_ready, bus.tx_frame_stb, bus.tx_bytes_stb, bus.tx_bytes_amt, bus.tx_stall};

  function automatic logic [83:0] ex(input logic v, input logic [1:0] u, input logic [7:0] s,
                                     input logic [63:0] d, input logic rr, input logic fs,
                                     input logic bs, input logic [3:0] amt, input logic st);
    return {v, u[1], u, s, d, rr, fs, bs, amt, st};
  endfunction

  function automatic logic [63:0] hdr(input logic [15:0] s, input logic [7:0] l,
                                      input logic [7:0] t);
    return {32'h0, s, l, t};
  endfunction

  // Called on a falling edge; returns on the falling edge where the header is visible.
  task automatic send_req(input logic [7:0] t, input logic [2:0] w, input logic [3:0] lb,
                          input logic [255:0] pl);
    int k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (k >= 20) $display("FAIL req_ready_wait got=timeout want=ready within 20 cycles");
    else n_pass++;
    bus.req_valid      = 1'b1;
    bus.req_type       = t;
    bus.req_words      = w;
    bus.req_last_bytes = lb;
    bus.req_payload    = pl;
    @(negedge clk);
    bus.req_valid = 1'b0;
    $display("req type=%h words=%0d last_bytes=%0d", t, w, lb);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (obs !== 84'h0) $display("FAIL reset_hold got=%h want=%h", obs, 84'h0);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs !== ex(0, 2'b00, 8'h00, 64'h0, 1, 0, 0, 4'd0, 0))
      $display("FAIL reset_release got=%h want=%h", obs, ex(0, 2'b00, 8'h00, 64'h0, 1, 0, 0, 4'd0, 0));
    else n_pass++;
  endtask

  task automatic test_cqe();
    logic [83:0] e [3];
    e[0] = ex(1, 2'b11, 8'hFF, hdr(16'h0000, 8'h01, CQE), 0, 0, 0, 4'd0, 0);
    e[1] = ex(0, 2'b00, 8'h00, 64'h0, 1, 1, 0, 4'd0, 0);
    e[2] = ex(0, 2'b00, 8'h00, 64'h0, 1, 0, 0, 4'd0, 0);
    send_req(CQE, 3'd0, 4'd0, 256'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_total++;
      if (obs !== e[i]) $display("FAIL cqe_step%0d got=%h want=%h", i, obs, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_data();
    logic [83:0] e [5];
    e[0] = ex(1, 2'b01, 8'hFF, hdr(16'h0001, 8'h04, DATA), 0, 0, 0, 4'd0, 0);
    e[1] = ex(1, 2'b00, 8'hFF, P0, 0, 1, 0, 4'd0, 0);
    e[2] = ex(1, 2'b00, 8'hFF, P1, 0, 0, 1, 4'd8, 0);
    e[3] = ex(1, 2'b10, 8'h1F, P2, 0, 0, 1, 4'd8, 0);
    e[4] = ex(0, 2'b00, 8'h00, 64'h0, 1, 0, 1, 4'd5, 0);
    send_req(DATA, 3'd3, 4'd5, {64'h0, P2, P1, P0});
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_total++;
      if (obs !== e[i]) $display("FAIL data_step%0d got=%h want=%h", i, obs, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [83:0] e [8];
    e[0] = ex(1, 2'b01, 8'hFF, hdr(16'h0002, 8'h04, DATA), 0, 0, 0, 4'd0, 0);
    e[1] = ex(1, 2'b00, 8'hFF, P0, 0, 1, 0, 4'd0, 0);
    e[2] = ex(1, 2'b00, 8'hFF, P1, 0, 0, 1, 4'd8, 0);
    e[3] = ex(1, 2'b00, 8'hFF, P1, 0, 0, 0, 4'd0, 1);
    e[4] = e[3];
    e[5] = e[3];
    e[6] = ex(1, 2'b10, 8'h1F, P2, 0, 0, 1, 4'd8, 0);
    e[7] = ex(0, 2'b00, 8'h00, 64'h0, 1, 0, 1, 4'd5, 0);
    send_req(DATA, 3'd3, 4'd5, {64'h0, P2, P1, P0});
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_total++;
      if (obs !== e[i]) $display("FAIL stall_step%0d got=%h want=%h", i, obs, e[i]);
      else n_pass++;
      if (i == 2) bus.ob_tready = 1'b0;
      if (i == 5) bus.ob_tready = 1'b1;
    end
  endtask

  task automatic test_seq_wrap();
    logic [15:0] s [3];
    s[0] = 16'hFFFE;
    s[1] = 16'hFFFF;
    s[2] = 16'h0000;
    force dut.seq_q = 16'hFFFE;
    @(negedge clk);
    release dut.seq_q;
    for (int i = 0; i < 3; i++) begin
      send_req(CQE, 3'd0, 4'd0, 256'h0);
      n_total++;
      if (obs !== ex(1, 2'b11, 8'hFF, hdr(s[i], 8'h01, CQE), 0, 0, 0, 4'd0, 0))
        $display("FAIL wrap_hdr%0d got=%h want=%h", i, obs,
                 ex(1, 2'b11, 8'hFF, hdr(s[i], 8'h01, CQE), 0, 0, 0, 4'd0, 0));
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (obs !== ex(0, 2'b00, 8'h00, 64'h0, 1, 1, 0, 4'd0, 0))
        $display("FAIL wrap_stb%0d got=%h want=%h", i, obs, ex(0, 2'b00, 8'h00, 64'h0, 1, 1, 0, 4'd0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [83:0] e [3];
    e[0] = ex(1, 2'b01, 8'hFF, hdr(16'h0001, 8'h05, DATA), 0, 0, 0, 4'd0, 0);
    e[1] = ex(1, 2'b00, 8'hFF, P0, 0, 1, 0, 4'd0, 0);
    e[2] = ex(1, 2'b00, 8'hFF, P1, 0, 0, 1, 4'd8, 0);
    send_req(DATA, 3'd4, 4'd8, {P3, P2, P1, P0});
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_total++;
      if (obs !== e[i]) $display("FAIL midrst_step%0d got=%h want=%h", i, obs, e[i]);
      else n_pass++;
    end
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (obs !== 84'h0) $display("FAIL midrst_async got=%h want=%h", obs, 84'h0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs !== ex(0, 2'b00, 8'h00, 64'h0, 1, 0, 0, 4'd0, 0))
      $display("FAIL midrst_release got=%h want=%h", obs, ex(0, 2'b00, 8'h00, 64'h0, 1, 0, 0, 4'd0, 0));
    else n_pass++;
    send_req(CQE, 3'd0, 4'd0, 256'h0);
    n_total++;
    if (obs !== ex(1, 2'b11, 8'hFF, hdr(16'h0000, 8'h01, CQE), 0, 0, 0, 4'd0, 0))
      $display("FAIL midrst_seq0 got=%h want=%h", obs,
               ex(1, 2'b11, 8'hFF, hdr(16'h0000, 8'h01, CQE), 0, 0, 0, 4'd0, 0));
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_clamp();
    logic [83:0] e [6];
    e[0] = ex(1, 2'b01, 8'hFF, hdr(16'h0001, 8'h05, RQE), 0, 0, 0, 4'd0, 0);
    e[1] = ex(1, 2'b00, 8'hFF, P0, 0, 1, 0, 4'd0, 0);
    e[2] = ex(1, 2'b00, 8'hFF, P1, 0, 0, 1, 4'd8, 0);
    e[3] = ex(1, 2'b00, 8'hFF, P2, 0, 0, 1, 4'd8, 0);
    e[4] = ex(1, 2'b10, 8'hFF, P3, 0, 0, 1, 4'd8, 0);
    e[5] = ex(0, 2'b00, 8'h00, 64'h0, 1, 0, 1, 4'd8, 0);
    send_req(RQE, 3'd7, 4'd0, {P3, P2, P1, P0});
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      n_total++;
      if (obs !== e[i]) $display("FAIL clamp_step%0d got=%h want=%h", i, obs, e[i]);
      else n_pass++;
    end
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_type       = 8'h00;
    bus.req_words      = 3'd0;
    bus.req_last_bytes = 4'd0;
    bus.req_payload    = '0;
    bus.ob_tready      = 1'b1;
    test_reset();
    test_cqe();
    test_data();
    test_stall();
    test_seq_wrap();
    test_reset_mid_frame();
    test_clamp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=bench complete");
    $fatal(1, "watchdog expired");
  end
endmodule
